// File: rtl/bitstream_flash_reader.sv
// SPI-flash boot reader: issues a READ (0x03) at the selected slot's byte address
// and streams 32-bit bitstream words out as single-cycle valid pulses.
module bitstream_flash_reader #(
   parameter int unsigned BITSTREAM_LENGTH_WORDS = 32'h11D6,
   parameter int unsigned SLOT_OFFSET_WORDS      = 32'h2000,
   parameter int unsigned NUM_SLOTS              = 16,
   parameter int unsigned CLK_DIV                = 1,
   parameter int unsigned CS_HIGH_CYCLES         = 4,
   localparam int unsigned SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [SLOT_W-1:0] slot_i,
   output logic [31:0]       bitstream_data_o,
   output logic              bitstream_valid_o,
   output logic              busy_o,
   output logic              sclk_o,
   output logic              cs_no,
   output logic              mosi_o,
   input  logic              miso_i
);

   localparam int unsigned WORD_W    = $clog2(BITSTREAM_LENGTH_WORDS + 1);
   localparam int unsigned DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned HOLD_W    = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;
   // The IDLE cycle that follows CS_HOLD also keeps cs_no high, so CS_HOLD
   // itself lasts one cycle less than the required high time (minimum one).
   localparam int unsigned HOLD_LAST = (CS_HIGH_CYCLES > 2) ? CS_HIGH_CYCLES - 2 : 0;
   localparam logic [7:0]  READ_CMD  = 8'h03;

   typedef enum logic [2:0] {
      IDLE, SETUP, SHIFT_CMD, SHIFT_ADDR, SHIFT_DATA, CS_HOLD
   } state_t;

   state_t              state, next_state;
   logic [SLOT_W-1:0]   slot_q;
   logic [DIV_W-1:0]    div_cnt;
   logic                sclk_q;
   logic [4:0]          bit_cnt;
   logic [31:0]         shift_out;
   logic [30:0]         rx_shift;
   logic [31:0]         data_q;
   logic                valid_q;
   logic [WORD_W-1:0]   word_cnt;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [23:0]         addr;
   logic                tick, in_shift, rise, fall, last_word_out;

   assign addr          = 24'(24'(slot_q) * 24'(SLOT_OFFSET_WORDS) * 24'd4);
   assign tick          = (div_cnt == DIV_W'(CLK_DIV - 1));
   assign in_shift      = (state == SHIFT_CMD) || (state == SHIFT_ADDR) || (state == SHIFT_DATA);
   assign rise          = in_shift && tick && !sclk_q;
   assign fall          = in_shift && tick && sclk_q;
   assign last_word_out = (state == SHIFT_DATA) && valid_q &&
                          (word_cnt == WORD_W'(BITSTREAM_LENGTH_WORDS));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:       if (start_i) next_state = SETUP;
         SETUP:      if (tick) next_state = SHIFT_CMD;
         SHIFT_CMD:  if (fall && bit_cnt == 5'd7) next_state = SHIFT_ADDR;
         SHIFT_ADDR: if (fall && bit_cnt == 5'd23) next_state = SHIFT_DATA;
         SHIFT_DATA: if (last_word_out) next_state = CS_HOLD;
         CS_HOLD:    if (hold_cnt == HOLD_W'(HOLD_LAST)) next_state = IDLE;
         default:    next_state = IDLE;
      endcase
   end

   always_comb begin
      cs_no  = 1'b0;
      busy_o = 1'b1;
      mosi_o = 1'b0;
      case (state)
         IDLE: begin
            cs_no  = 1'b1;
            busy_o = 1'b0;
         end
         SETUP:                 mosi_o = READ_CMD[7];
         SHIFT_CMD, SHIFT_ADDR: mosi_o = shift_out[31];
         CS_HOLD:               cs_no  = 1'b1;
         default:               mosi_o = 1'b0;
      endcase
   end

   assign sclk_o            = sclk_q;
   assign bitstream_valid_o = valid_q;
   assign bitstream_data_o  = data_q;

   // Bit engine: sclk toggles every CLK_DIV cycles; mosi advances on the
   // high->low transition, miso is captured on the low->high transition.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         slot_q    <= '0;
         div_cnt   <= '0;
         sclk_q    <= 1'b0;
         bit_cnt   <= '0;
         shift_out <= '0;
         rx_shift  <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         word_cnt  <= '0;
         hold_cnt  <= '0;
      end else begin
         valid_q <= 1'b0;
         if (state == IDLE && start_i) slot_q <= slot_i;

         if ((state == SETUP || in_shift) && next_state != CS_HOLD)
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
         else
            div_cnt <= '0;

         if (in_shift && next_state != CS_HOLD) begin
            if (tick) sclk_q <= ~sclk_q;
         end else begin
            sclk_q <= 1'b0;
         end

         if (state == SETUP)  shift_out <= {READ_CMD, addr};
         else if (fall)       shift_out <= {shift_out[30:0], 1'b0};

         if (fall)            bit_cnt <= (next_state != state) ? 5'd0 : bit_cnt + 5'd1;
         else if (!in_shift)  bit_cnt <= 5'd0;

         if (rise && state == SHIFT_DATA) begin
            rx_shift <= {rx_shift[29:0], miso_i};
            if (bit_cnt == 5'd31) begin
               data_q   <= {rx_shift, miso_i};
               valid_q  <= 1'b1;
               word_cnt <= word_cnt + 1'b1;
            end
         end else if (state == IDLE) begin
            word_cnt <= '0;
         end

         if (state == CS_HOLD) hold_cnt <= hold_cnt + 1'b1;
         else                  hold_cnt <= '0;
      end
   end

endmodule
